reg_writeback_unit: RTL
=======================

// Module: reg_writeback_unit
// PURPOSE
//  Write-side front end of the 2R/1W register file. Collects results from two producers
//  (ALU and memory/load unit) through valid/ready channels and buffers them per channel.
//  Arbitrates them onto the single register-file write port (wrData/wrNum/wrEnable).
//  Provides combinational pending-write flags for the two read register numbers, used by
//  decode to detect RAW hazards. Sits between the execute/memory stages and the register file.
// PARAMETERS
//  DATA_W     32  width of result data (matches `DataPath)
//  REGNUM_W   5   width of register number (matches `RegNumPath); REG_FILE_SIZE = 2**REGNUM_W
//  BUF_DEPTH  2   entries per channel FIFO; power of two, >= 2
// PORTS
//  clk       in   1         clock, all state updates on posedge
//  rst       in   1         reset, synchronous, active-low (0 = reset)
//  aluValid  in   1         ALU result valid
//  aluReady  out  1         ALU channel can accept (FIFO not full)
//  aluNum    in   REGNUM_W  ALU destination register
//  aluData   in   DATA_W    ALU result
//  memValid  in   1         load result valid
//  memReady  out  1         load channel can accept (FIFO not full)
//  memNum    in   REGNUM_W  load destination register
//  memData   in   DATA_W    load result
//  wrEnable  out  1         register-file write enable (registered)
//  wrNum     out  REGNUM_W  register-file write number (registered)
//  wrData    out  DATA_W    register-file write data (registered)
//  rdNumA    in   REGNUM_W  decode read number A, for hazard lookup
//  rdNumB    in   REGNUM_W  decode read number B, for hazard lookup
//  pendA     out  1         queued or in-flight write targets rdNumA
//  pendB     out  1         queued or in-flight write targets rdNumB
//  idle      out  1         both FIFOs empty and wrEnable==0
// BEHAVIOUR
//  - Reset (rst==0 at posedge): both FIFOs emptied (contents discarded, even mid-drain).
//    wrEnable=0, wrNum=0, wrData=0, RR pointer=MEM. aluReady=memReady=0 while rst==0.
//  - Channel transfer on posedge when xValid && xReady. xReady = !full only; no pass-through,
//    so a push into a full FIFO is impossible even if a pop occurs in the same cycle.
//    Push and pop of the same FIFO in one cycle are legal when not full; count is unchanged.
//  - Per-channel FIFO order is preserved. Pointers wrap modulo BUF_DEPTH; full/empty are
//    distinguished by a count or an extra pointer bit.
//  - Arbiter: each cycle at most one head is popped. Exactly one FIFO non-empty -> pop it.
//    Both non-empty -> pop the channel named by the RR pointer, then point to the other one.
//    RR pointer changes only on a contended grant.
//  - Output register: on a pop, wrNum<=head.num, wrData<=head.data,
//    wrEnable<=(head.num!=0). A write to r0 is popped and dropped (wrEnable=0).
//    With no pop: wrEnable<=0; wrNum/wrData hold their previous values.
//  - Latency: entry accepted at edge k into an empty FIFO with no contention -> popped at
//    edge k+1 -> wrEnable=1 during cycle k+1 -> register file writes at edge k+2.
//    Throughput is 1 write/cycle total.
//  - Cross-channel writes to the same register retire in arbitration order. Producers must
//    not rely on ordering between channels; decode stalls on pend* instead.
//  - pendA = (rdNumA!=0) && (any valid FIFO entry num==rdNumA || (wrEnable && wrNum==rdNumA));
//    pendB is the same for rdNumB. Both are purely combinational from current state and rdNum*.
//  - idle = both FIFOs empty && !wrEnable.
// TESTING
//  1 Reset: rst=0 for 2 cycles with valids high -> readys=0, wrEnable=0, wrNum=0, wrData=0.
//    After rst=1 -> readys=1, idle=1.
//  2 Single ALU write: aluNum=5, aluData=32'hDEADBEEF accepted at edge k -> wrEnable=1,
//    wrNum=5, wrData=DEADBEEF in cycle k+1 only. pendA=1 while rdNumA=5 from k to k+1,
//    then 0.
//  3 Contention: both channels push 3 entries back-to-back (mem r1..r3, alu r11..r13) ->
//    write order r1,r11,r2,r12,r3,r13 with no bubble. aluReady drops after the 2nd push
//    until a pop frees an entry.
//  4 Zero register: memNum=0, memData=7 -> entry popped, wrEnable stays 0. pendA=0 with
//    rdNumA=0 throughout.
//  5 Full/backpressure: hold memValid=1 for 6 cycles while ALU is contended -> memReady=0
//    whenever the FIFO holds 2 entries. No entry is lost or duplicated; writes match the
//    push order.
//  6 Reset mid-drain: both FIFOs full, then rst=0 for 1 cycle -> next cycle wrEnable=0 and
//    idle=1 after release. No queued write appears.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - two-channel buffered register-file write port with hazard lookup
module reg_writeback_unit #(
  parameter int DATA_W    = 32,
  parameter int REGNUM_W  = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aluValid,
  output logic                aluReady,
  input  logic [REGNUM_W-1:0] aluNum,
  input  logic [DATA_W-1:0]   aluData,
  input  logic                memValid,
  output logic                memReady,
  input  logic [REGNUM_W-1:0] memNum,
  input  logic [DATA_W-1:0]   memData,
  output logic                wrEnable,
  output logic [REGNUM_W-1:0] wrNum,
  output logic [DATA_W-1:0]   wrData,
  input  logic [REGNUM_W-1:0] rdNumA,
  input  logic [REGNUM_W-1:0] rdNumB,
  output logic                pendA,
  output logic                pendB,
  output logic                idle
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BUF_DEPTH);

  logic [REGNUM_W-1:0] aluNumQ  [BUF_DEPTH];
  logic [DATA_W-1:0]   aluDataQ [BUF_DEPTH];
  logic [REGNUM_W-1:0] memNumQ  [BUF_DEPTH];
  logic [DATA_W-1:0]   memDataQ [BUF_DEPTH];

  logic [PTR_W-1:0] aluRdPtr, aluWrPtr, memRdPtr, memWrPtr;
  logic [PTR_W:0]   aluCnt, memCnt;
  logic             rrMem;  // 1: next contended grant goes to the load channel
  logic             aluPush, memPush, aluPop, memPop, aluNe, memNe;
  logic [REGNUM_W-1:0] headNum;
  logic [DATA_W-1:0]   headData;
  logic             hitA, hitB;

  // No pass-through: readiness depends only on occupancy, and is forced low in reset
  assign aluReady = rst && (aluCnt != FULL_CNT);
  assign memReady = rst && (memCnt != FULL_CNT);
  assign aluPush  = aluValid && aluReady;
  assign memPush  = memValid && memReady;
  assign aluNe    = (aluCnt != '0);
  assign memNe    = (memCnt != '0);

  // Round-robin only matters when both heads are waiting
  always_comb begin
    aluPop = 1'b0;
    memPop = 1'b0;
    if (aluNe && memNe) begin
      if (rrMem) memPop = 1'b1;
      else       aluPop = 1'b1;
    end else if (aluNe) begin
      aluPop = 1'b1;
    end else if (memNe) begin
      memPop = 1'b1;
    end
  end

  assign headNum  = memPop ? memNumQ[memRdPtr]  : aluNumQ[aluRdPtr];
  assign headData = memPop ? memDataQ[memRdPtr] : aluDataQ[aluRdPtr];

  // ALU channel FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      aluCnt   <= '0;
      aluRdPtr <= '0;
      aluWrPtr <= '0;
    end else begin
      if (aluPush) begin
        aluNumQ[aluWrPtr]  <= aluNum;
        aluDataQ[aluWrPtr] <= aluData;
        aluWrPtr           <= aluWrPtr + PTR_W'(1);
      end
      if (aluPop) aluRdPtr <= aluRdPtr + PTR_W'(1);
      aluCnt <= aluCnt + (PTR_W+1)'(aluPush) - (PTR_W+1)'(aluPop);
    end
  end

  // Load channel FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      memCnt   <= '0;
      memRdPtr <= '0;
      memWrPtr <= '0;
    end else begin
      if (memPush) begin
        memNumQ[memWrPtr]  <= memNum;
        memDataQ[memWrPtr] <= memData;
        memWrPtr           <= memWrPtr + PTR_W'(1);
      end
      if (memPop) memRdPtr <= memRdPtr + PTR_W'(1);
      memCnt <= memCnt + (PTR_W+1)'(memPush) - (PTR_W+1)'(memPop);
    end
  end

  // Arbiter pointer and registered write port; r0 writes are consumed but never enabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      rrMem    <= 1'b1;
      wrEnable <= 1'b0;
      wrNum    <= '0;
      wrData   <= '0;
    end else begin
      if (aluNe && memNe) rrMem <= !rrMem;
      if (aluPop || memPop) begin
        wrNum    <= headNum;
        wrData   <= headData;
        wrEnable <= (headNum != '0);
      end else begin
        wrEnable <= 1'b0;
      end
    end
  end

  // Hazard lookup over live FIFO slots plus the write currently on the port
  always_comb begin
    hitA = wrEnable && (wrNum == rdNumA);
    hitB = wrEnable && (wrNum == rdNumB);
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - aluRdPtr} < aluCnt) begin
        if (aluNumQ[PTR_W'(i)] == rdNumA) hitA = 1'b1;
        if (aluNumQ[PTR_W'(i)] == rdNumB) hitB = 1'b1;
      end
      if ({1'b0, PTR_W'(i) - memRdPtr} < memCnt) begin
        if (memNumQ[PTR_W'(i)] == rdNumA) hitA = 1'b1;
        if (memNumQ[PTR_W'(i)] == rdNumB) hitB = 1'b1;
      end
    end
  end

  assign pendA = (rdNumA != '0) && hitA;
  assign pendB = (rdNumB != '0) && hitB;
  assign idle  = !aluNe && !memNe && !wrEnable;

endmodule
